// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack bus, stall, registered load data.
// Optional MEM_ACCESS_STATS_EN adds LoadCount/StoreCount/StallCycles counters.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemStall,
  output logic              AddrError,
  output logic              AccessError,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ACCESS_STATS_EN
  output logic [15:0]       LoadCount,
  output logic [15:0]       StoreCount,
  output logic [15:0]       StallCycles,
`endif
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                aerr_q, aerr_d;
  logic                accerr_q, accerr_d;

  logic       access;
  logic       aligned;
  logic [7:0] cnt_inc;

  assign access  = MemRead | MemWrite;
  assign aligned = (ALUresult[1:0] == 2'b00);
  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      aerr_q   <= 1'b0;
      accerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      aerr_q   <= aerr_d;
      accerr_q <= accerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    aerr_d   = 1'b0;
    accerr_d = accerr_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            addr_d  = ALUresult;
            wdata_d = WriteData;
            we_d    = MemWrite;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            aerr_d = 1'b1;
          end
        end
      end
      REQ: begin
        // an ack on the timeout cycle still completes the access
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_inc == TO) begin
          cnt_d    = cnt_inc;
          req_d    = 1'b0;
          accerr_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign MemStall = reset_n &
                    (((state_q == IDLE) & access & aligned) |
                     (state_q == REQ));

  assign ReadData    = rdata_q;
  assign AddrError   = aerr_q;
  assign AccessError = accerr_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] ld_q, st_q, stl_q;
  logic        acked;

  assign acked = (state_q == REQ) & mem_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ld_q  <= '0;
      st_q  <= '0;
      stl_q <= '0;
    end else begin
      if (acked & !we_q & (ld_q != 16'hFFFF)) ld_q <= ld_q + 16'd1;
      if (acked & we_q & (st_q != 16'hFFFF)) st_q <= st_q + 16'd1;
      if (MemStall & (stl_q != 16'hFFFF)) stl_q <= stl_q + 16'd1;
    end
  end

  assign LoadCount   = ld_q;
  assign StoreCount  = st_q;
  assign StallCycles = stl_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit (TIMEOUT=4).
// Rows: inputs for one cycle and outputs expected before that cycle's edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [31:0] ALUresult, WriteData;
  logic [31:0] ReadData;
  logic        MemStall, AddrError, AccessError;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] LoadCount, StoreCount, StallCycles;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUresult(ALUresult), .WriteData(WriteData),
    .ReadData(ReadData), .MemStall(MemStall),
    .AddrError(AddrError), .AccessError(AccessError),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef MEM_ACCESS_STATS_EN
    .LoadCount(LoadCount), .StoreCount(StoreCount),
    .StallCycles(StallCycles),
`endif
    .mem_ack(mem_ack)
  );

  typedef struct {
    logic        rst, rd, wr;
    logic [31:0] addr, wd;
    logic        ack;
    logic [31:0] rdat;
    logic        req, we;
    logic [31:0] maddr, mwd;
    logic        stall;
    logic [31:0] rdo;
    logic        aerr, accerr;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(
    input logic rst, rd, wr, input logic [31:0] addr, wd,
    input logic ack, input logic [31:0] rdat,
    input logic req, we, input logic [31:0] maddr, mwd,
    input logic stall, input logic [31:0] rdo,
    input logic aerr, accerr);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.ack = ack; v.rdat = rdat; v.req = req; v.we = we;
    v.maddr = maddr; v.mwd = mwd; v.stall = stall; v.rdo = rdo;
    v.aerr = aerr; v.accerr = accerr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    logic [99:0] got, exp;
    bit          seen;
    // rst rd wr addr wd ack rdat | req we maddr mwd stall rdo aerr accerr
    add(0,1,0,32'h10,0,0,0,               0,0,32'h00,0,0,0,0,0);           // 0
    add(1,1,0,32'h10,0,0,0,               0,0,32'h00,0,1,0,0,0);           // 1
    add(1,1,0,32'h10,0,0,0,               1,0,32'h10,0,1,0,0,0);           // 2
    add(1,1,0,32'h10,0,0,0,               1,0,32'h10,0,1,0,0,0);           // 3
    add(1,1,0,32'h10,0,0,0,               1,0,32'h10,0,1,0,0,0);           // 4
    add(1,1,0,32'h10,0,1,32'hDEADBEEF,    1,0,32'h10,0,1,0,0,0);           // 5
    add(1,1,0,32'h10,0,0,0,               0,0,32'h10,0,0,32'hDEADBEEF,0,0);// 6
    add(1,0,0,32'h00,0,1,32'h11111111,    0,0,32'h10,0,0,32'hDEADBEEF,0,0);// 7
    add(1,0,1,32'h24,32'h12345678,0,0,    0,0,32'h10,0,1,32'hDEADBEEF,0,0);// 8
    add(1,0,1,32'h24,32'h12345678,1,32'h55555555,
        1,1,32'h24,32'h12345678,1,32'hDEADBEEF,0,0);                       // 9
    add(1,0,1,32'h24,32'h12345678,0,0,
        0,1,32'h24,32'h12345678,0,32'hDEADBEEF,0,0);                       // 10
    add(1,1,0,32'h13,0,0,0,   0,1,32'h24,32'h12345678,0,32'hDEADBEEF,0,0); // 11
    add(1,0,0,32'h00,0,0,0,   0,1,32'h24,32'h12345678,0,32'hDEADBEEF,1,0); // 12
    add(1,0,0,32'h00,0,0,0,   0,1,32'h24,32'h12345678,0,32'hDEADBEEF,0,0); // 13
    add(1,1,0,32'h40,0,0,0,   0,1,32'h24,32'h12345678,1,32'hDEADBEEF,0,0); // 14
    for (int k = 0; k < 4; k++)
      add(1,1,0,32'h40,0,0,0, 1,0,32'h40,0,1,32'hDEADBEEF,0,0);            // 15-18
    add(1,1,0,32'h40,0,0,0,   0,0,32'h40,0,0,32'hDEADBEEF,0,1);            // 19
    add(1,0,0,32'h00,0,1,32'h99, 0,0,32'h40,0,0,32'hDEADBEEF,0,1);         // 20
    add(1,1,1,32'h80,32'hA5A5A5A5,0,0, 0,0,32'h40,0,1,32'hDEADBEEF,0,1);   // 21
    add(1,1,1,32'h80,32'hA5A5A5A5,1,32'h77777777,
        1,1,32'h80,32'hA5A5A5A5,1,32'hDEADBEEF,0,1);                       // 22
    add(1,0,0,32'h00,0,0,0, 0,1,32'h80,32'hA5A5A5A5,0,32'hDEADBEEF,0,1);   // 23
    add(1,1,0,32'h00,0,0,0, 0,1,32'h80,32'hA5A5A5A5,1,32'hDEADBEEF,0,1);   // 24
    add(1,1,0,32'h00,0,1,32'h0BADF00D, 1,0,32'h00,0,1,32'hDEADBEEF,0,1);   // 25
    add(1,0,0,32'h00,0,0,0,   0,0,32'h00,0,0,32'h0BADF00D,0,1);            // 26
    add(1,1,0,32'h08,0,0,0,   0,0,32'h00,0,1,32'h0BADF00D,0,1);            // 27
    add(1,0,0,32'h00,0,0,0,   1,0,32'h08,0,1,32'h0BADF00D,0,1);            // 28
    vq[28].rst = 1'b0;
    vq[28].stall = 1'b0;
    add(1,0,0,32'h00,0,1,32'hFFFF, 0,0,32'h00,0,0,0,0,0);                  // 29
    add(1,0,0,32'h00,0,0,0,   0,0,32'h00,0,0,0,0,0);                       // 30

    reset_n = 0; MemRead = 1; MemWrite = 0; ALUresult = 32'h10;
    WriteData = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vq[i]) begin
      reset_n = vq[i].rst; MemRead = vq[i].rd; MemWrite = vq[i].wr;
      ALUresult = vq[i].addr; WriteData = vq[i].wd;
      mem_ack = vq[i].ack; mem_rdata = vq[i].rdat;
      @(negedge clk);
      got = {mem_req, mem_we, mem_addr, mem_wdata, MemStall,
             ReadData, AddrError, AccessError};
      exp = {vq[i].req, vq[i].we, vq[i].maddr, vq[i].mwd, vq[i].stall,
             vq[i].rdo, vq[i].aerr, vq[i].accerr};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL row%0d: req=%b we=%b addr=%h wd=%h stall=%b rd=%h ae=%b acc=%b expected %h",
                 i, mem_req, mem_we, mem_addr, mem_wdata, MemStall,
                 ReadData, AddrError, AccessError, exp);
      end
`ifdef MEM_ACCESS_STATS_EN
      if (i == 26) begin
        chk("LoadCount", 64'(LoadCount), 64'd2);
        chk("StoreCount", 64'(StoreCount), 64'd2);
        chk("StallCycles", 64'(StallCycles), 64'd16);
      end
`endif
      @(posedge clk);
      #1;
    end

    // bounded wait on a fresh load, then ack it
    MemRead = 1; ALUresult = 32'h100; mem_ack = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = mem_req;
    end
    chk("req_wait", 64'(seen), 64'd1);
    if (seen) begin
      chk("req_addr", 64'(mem_addr), 64'h100);
      mem_ack = 1; mem_rdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      mem_ack = 0; MemRead = 0;
      @(negedge clk);
      chk("done_rdata", 64'(ReadData), 64'hCAFEF00D);
      chk("done_stall", 64'({MemStall, mem_req}), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
